// File: rtl/gtx_frame_rx.sv
// GTX 8b/10b receive deframer: comma lock, frame extraction and checking.
// Emits payload words, a per-frame status strobe and saturating counters.
module gtx_frame_rx #(
    parameter int MAX_LEN  = 256,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  ctrl_i,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    output logic        valid_o,
    output logic        first_o,
    output logic        last_o,
    output logic [7:0]  seq_o,
    output logic        done_o,
    output logic        ok_o,
    output logic        err_o,
    output logic [2:0]  err_code_o,
    output logic        seq_err_o,
    output logic        lock_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] err_cnt_o
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_BODY,
        S_CHK,
        S_EOF
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [15:0]     sum;
    logic            chk_ok;
    logic            first_pend;
    logic [7:0]      seq_ref;
    logic            ref_valid;
    logic [IW-1:0]   idle_cnt;
    logic [LW-1:0]   loss_cnt;

    logic is_k;
    logic is_data;
    logic is_idle;
    logic is_sof;
    logic is_eof;
    logic is_illegal;
    logic len_ok;
    logic loss_hit;
    logic fail;
    logic good;
    logic [2:0] code;

    assign is_k       = (ctrl_i == 2'b01);
    assign is_data    = (ctrl_i == 2'b00);
    assign is_idle    = is_k && (data_i == 16'h50BC);
    assign is_sof     = is_k && (data_i[7:0] == 8'hFB);
    assign is_eof     = is_k && (data_i == 16'h00FD);
    assign is_illegal = ctrl_i[1] || (is_k && !is_idle && !is_sof && !is_eof);
    assign len_ok     = (data_i != 16'h0000) && (data_i <= 16'(MAX_LEN));
    assign loss_hit   = lock_o && is_illegal && (loss_cnt == LW'(LOSS_CNT - 1));

    // Frame verdict for the word on the input this cycle.
    always_comb begin
        fail = 1'b0;
        good = 1'b0;
        code = 3'd0;
        if (loss_hit) begin
            if (state != S_HUNT) begin
                fail = 1'b1;
                code = 3'd5;
            end
        end else if (lock_o) begin
            unique case (state)
                S_HUNT: ;
                S_LEN: begin
                    if (!is_data) begin
                        fail = 1'b1;
                        code = 3'd2;
                    end else if (!len_ok) begin
                        fail = 1'b1;
                        code = 3'd1;
                    end
                end
                S_BODY, S_CHK: begin
                    if (!is_data) begin
                        fail = 1'b1;
                        code = 3'd2;
                    end
                end
                S_EOF: begin
                    if (is_eof) begin
                        good = chk_ok;
                        fail = !chk_ok;
                        code = chk_ok ? 3'd0 : 3'd3;
                    end else if (is_data) begin
                        fail = 1'b1;
                        code = 3'd4;
                    end else if (is_k) begin
                        fail = 1'b1;
                        code = 3'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_o   <= 1'b0;
            idle_cnt <= '0;
            loss_cnt <= '0;
        end else if (!lock_o) begin
            loss_cnt <= '0;
            if (!is_idle) begin
                idle_cnt <= '0;
            end else if (idle_cnt == IW'(LOCK_CNT - 1)) begin
                idle_cnt <= '0;
                lock_o   <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end else if (!is_illegal) begin
            loss_cnt <= '0;
        end else if (loss_hit) begin
            loss_cnt <= '0;
            lock_o   <= 1'b0;
        end else begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_HUNT;
            cnt         <= '0;
            sum         <= '0;
            chk_ok      <= 1'b0;
            first_pend  <= 1'b0;
            seq_ref     <= '0;
            ref_valid   <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            first_o     <= 1'b0;
            last_o      <= 1'b0;
            seq_o       <= '0;
            done_o      <= 1'b0;
            ok_o        <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= '0;
            seq_err_o   <= 1'b0;
            frame_cnt_o <= '0;
            err_cnt_o   <= '0;
        end else begin
            valid_o    <= 1'b0;
            first_o    <= 1'b0;
            last_o     <= 1'b0;
            done_o     <= fail | good;
            ok_o       <= good;
            err_o      <= fail;
            err_code_o <= code;
            seq_err_o  <= good && ref_valid && (seq_o != seq_ref + 8'd1);
            if (good) begin
                seq_ref   <= seq_o;
                ref_valid <= 1'b1;
                if (frame_cnt_o != 16'hFFFF) frame_cnt_o <= frame_cnt_o + 1'b1;
            end
            if (fail && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 1'b1;

            if (loss_hit) begin
                state     <= S_HUNT;
                ref_valid <= 1'b0;
            end else if (lock_o) begin
                // A SOF seen in any frame state restarts framing on that word.
                if (is_sof) begin
                    seq_o <= data_i[15:8];
                    sum   <= '0;
                    state <= S_LEN;
                end else begin
                    unique case (state)
                        S_HUNT: ;
                        S_LEN: begin
                            if (is_data && len_ok) begin
                                cnt        <= data_i[CW-1:0];
                                sum        <= data_i;
                                first_pend <= 1'b1;
                                state      <= S_BODY;
                            end else begin
                                state <= S_HUNT;
                            end
                        end
                        S_BODY: begin
                            if (is_data) begin
                                valid_o    <= 1'b1;
                                data_o     <= data_i;
                                first_o    <= first_pend;
                                last_o     <= (cnt == CW'(1));
                                first_pend <= 1'b0;
                                sum        <= sum + data_i;
                                cnt        <= cnt - 1'b1;
                                if (cnt == CW'(1)) state <= S_CHK;
                            end else begin
                                state <= S_HUNT;
                            end
                        end
                        S_CHK: begin
                            if (is_data) begin
                                chk_ok <= (data_i == sum);
                                state  <= S_EOF;
                            end else begin
                                state <= S_HUNT;
                            end
                        end
                        S_EOF: begin
                            if (!ctrl_i[1]) state <= S_HUNT;
                        end
                        default: state <= S_HUNT;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_gtx_frame_rx.sv
// Bench for gtx_frame_rx: directed and random frames against a frame-level model.
module tb_gtx_frame_rx;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  ctrl_i;
    logic [15:0] data_i;
    logic [15:0] data_o;
    logic        valid_o, first_o, last_o;
    logic [7:0]  seq_o;
    logic        done_o, ok_o, err_o, seq_err_o, lock_o;
    logic [2:0]  err_code_o;
    logic [15:0] frame_cnt_o, err_cnt_o;

    gtx_frame_rx dut (
        .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .data_i(data_i),
        .data_o(data_o), .valid_o(valid_o), .first_o(first_o),
        .last_o(last_o), .seq_o(seq_o), .done_o(done_o), .ok_o(ok_o),
        .err_o(err_o), .err_code_o(err_code_o), .seq_err_o(seq_err_o),
        .lock_o(lock_o), .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       ok;
        logic       err;
        logic [2:0] code;
        logic       seq_err;
        logic [7:0] seq;
    } ev_t;

    ev_t         got_ev[$];
    ev_t         exp_ev[$];
    logic [17:0] got_w[$];
    logic [17:0] exp_w[$];
    logic [15:0] pl[$];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_good = 0;
    int         m_bad = 0;
    bit         m_ref_v = 0;
    logic [7:0] m_ref = '0;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (valid_o) got_w.push_back({first_o, last_o, data_o});
            if (done_o) got_ev.push_back({ok_o, err_o, err_code_o, seq_err_o, seq_o});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [1:0] c, input logic [15:0] d);
        ctrl_i = c;
        data_i = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idles(input int n);
        repeat (n) put(2'b01, 16'h50BC);
    endtask

    task automatic sof(input logic [7:0] s);
        put(2'b01, {s, 8'hFB});
    endtask

    task automatic model_good(input logic [7:0] s);
        ev_t e;
        e = '0;
        e.ok = 1'b1;
        e.seq = s;
        e.seq_err = m_ref_v && (s != 8'(m_ref + 8'd1));
        m_ref = s;
        m_ref_v = 1;
        m_good++;
        exp_ev.push_back(e);
    endtask

    task automatic model_fail(input logic [2:0] c);
        ev_t e;
        e = '0;
        e.err = 1'b1;
        e.code = c;
        m_bad++;
        exp_ev.push_back(e);
    endtask

    // Sends SOF, LEN, payload from pl, the given checksum and EOF.
    task automatic frame_q(input logic [7:0] s, input logic [15:0] chk);
        logic [15:0] want;
        int n;
        n = pl.size();
        want = 16'(n);
        sof(s);
        put(2'b00, 16'(n));
        for (int i = 0; i < n; i++) begin
            put(2'b00, pl[i]);
            exp_w.push_back({i == 0, i == n - 1, pl[i]});
            want = want + pl[i];
        end
        put(2'b00, chk);
        put(2'b01, 16'h00FD);
        if (chk == want) model_good(s);
        else model_fail(3'd3);
    endtask

    task automatic fill(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(16'($urandom));
    endtask

    function automatic logic [15:0] good_chk();
        logic [15:0] s;
        s = 16'(pl.size());
        foreach (pl[i]) s = s + pl[i];
        return s;
    endfunction

    task automatic compare(input string tag);
        int nw, ne;
        idles(3);
        check({tag, ".words"}, got_w.size(), exp_w.size());
        nw = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < nw; i++) check({tag, ".word"}, got_w[i], exp_w[i]);
        check({tag, ".dones"}, got_ev.size(), exp_ev.size());
        ne = (got_ev.size() < exp_ev.size()) ? got_ev.size() : exp_ev.size();
        for (int i = 0; i < ne; i++) begin
            check({tag, ".ok"}, got_ev[i].ok, exp_ev[i].ok);
            check({tag, ".err"}, got_ev[i].err, exp_ev[i].err);
            check({tag, ".code"}, got_ev[i].code, exp_ev[i].code);
            check({tag, ".seq_err"}, got_ev[i].seq_err, exp_ev[i].seq_err);
            if (exp_ev[i].ok) check({tag, ".seq"}, got_ev[i].seq, exp_ev[i].seq);
        end
        check({tag, ".frame_cnt"}, frame_cnt_o, m_good);
        check({tag, ".err_cnt"}, err_cnt_o, m_bad);
        got_w.delete();
        exp_w.delete();
        got_ev.delete();
        exp_ev.delete();
    endtask

    task automatic illegal4();
        repeat (4) put(2'b11, 16'($urandom));
    endtask

    initial begin
        logic [7:0] s;
        logic [15:0] c;
        rst_i  = 1'b1;
        ctrl_i = 2'b01;
        data_i = 16'h50BC;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst.lock", lock_o, 0);
        check("rst.valid", valid_o, 0);
        check("rst.done", done_o, 0);
        check("rst.seq", seq_o, 0);
        check("rst.cnts", {frame_cnt_o, err_cnt_o}, 0);
        rst_i = 1'b0;

        idles(15);
        put(2'b00, 16'h1234);
        check("lock.broken", lock_o, 0);
        idles(15);
        check("lock.15", lock_o, 0);
        idles(1);
        check("lock.16", lock_o, 1);
        idles(4);
        check("lock.hold", lock_o, 1);

        pl = '{16'h0001, 16'h0002, 16'h0003};
        frame_q(8'h07, 16'h0009);
        check("f7.seq_o", seq_o, 8'h07);
        idles(2);
        frame_q(8'h08, 16'h000A);
        sof(8'h20);
        put(2'b00, 16'h0000);
        model_fail(3'd1);
        idles(2);
        sof(8'h21);
        put(2'b00, 16'd257);
        model_fail(3'd1);
        put(2'b00, 16'h1111);
        put(2'b01, 16'h00FD);
        compare("basic");

        sof(8'h01);
        put(2'b00, 16'd4);
        fill(2);
        foreach (pl[i]) begin
            put(2'b00, pl[i]);
            exp_w.push_back({i == 0, 1'b0, pl[i]});
        end
        model_fail(3'd2);
        fill(1);
        frame_q(8'h02, good_chk());
        compare("restart");

        sof(8'h30);
        put(2'b00, 16'd5);
        fill(2);
        foreach (pl[i]) begin
            put(2'b00, pl[i]);
            exp_w.push_back({i == 0, 1'b0, pl[i]});
        end
        model_fail(3'd2);
        illegal4();
        m_ref_v = 0;
        check("loss.body", lock_o, 0);
        compare("loss_body");
        idles(16);
        check("relock1", lock_o, 1);

        fill(1);
        sof(8'h40);
        put(2'b00, 16'd1);
        put(2'b00, pl[0]);
        exp_w.push_back({1'b1, 1'b1, pl[0]});
        put(2'b00, good_chk());
        illegal4();
        model_fail(3'd5);
        m_ref_v = 0;
        check("loss.eof", lock_o, 0);
        compare("loss_eof");
        idles(16);
        check("relock2", lock_o, 1);

        fill(2);
        frame_q(8'h05, good_chk());
        fill(3);
        frame_q(8'h06, good_chk());
        fill(1);
        frame_q(8'h08, good_chk());
        compare("seq");

        fill(256);
        frame_q(8'h09, good_chk());
        s = 8'h09;
        for (int k = 0; k < 12; k++) begin
            s = s + (($urandom_range(3, 0) == 0) ? 8'd2 : 8'd1);
            fill($urandom_range(8, 1));
            c = good_chk();
            if ($urandom_range(3, 0) == 0) c = c ^ 16'(1 << $urandom_range(15, 0));
            frame_q(s, c);
            idles($urandom_range(3, 0));
        end
        compare("random");

        sof(8'h55);
        put(2'b00, 16'd3);
        put(2'b00, 16'hBEEF);
        rst_i = 1'b1;
        #1;
        check("midrst.lock", lock_o, 0);
        check("midrst.cnts", {frame_cnt_o, err_cnt_o}, 0);
        got_w.delete();
        got_ev.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_good = 0;
        m_bad = 0;
        m_ref_v = 0;
        compare("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
